// File: rtl/pll_reset_sequencer_if.sv
// PLL control/status bundle between the reset sequencer (slave) and the board/PLL side (master).
interface pll_reset_sequencer_if;
  localparam int unsigned RET_W   = 4;
  localparam int unsigned LOSS_W  = 8;
  localparam int unsigned STATE_W = 3;

  logic               pll_locked;
  logic               relock_req;
  logic               pll_rst;
  logic               sys_rst_n;
  logic               ready;
  logic               fault;
  logic [RET_W-1:0]   retries;
  logic [LOSS_W-1:0]  loss_count;
  logic [STATE_W-1:0] state;

  modport slave (
    input  pll_locked, relock_req,
    output pll_rst, sys_rst_n, ready, fault, retries, loss_count, state
  );

  modport master (
    output pll_locked, relock_req,
    input  pll_rst, sys_rst_n, ready, fault, retries, loss_count, state
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for a stable lock with retry/fault
// handling, and releases the downstream reset only while the lock holds.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4
) (
  input  logic                  clkin,
  input  logic                  rst_n,
  pll_reset_sequencer_if.slave  io_seq
);
  localparam int unsigned RET_W     = 4;
  localparam int unsigned LOSS_W    = 8;
  localparam int unsigned CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES);
  localparam logic [RET_W-1:0]  RET_LIMIT   = RET_W'(MAX_RETRIES);
  localparam logic [LOSS_W-1:0] LOSS_SAT    = '1;

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [RET_W-1:0]  r_retries;
  logic [LOSS_W-1:0] r_loss;
  logic              r_pll_rst;
  logic              r_sys_rst_n;
  logic              r_ready;
  logic              r_fault;

  logic              w_locked_s;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [RET_W-1:0]  w_retries_nxt;
  logic [RET_W-1:0]  w_retry_inc;
  logic [LOSS_W-1:0] w_loss_nxt;

  assign w_locked_s  = r_sync2;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_retry_inc = r_retries + RET_W'(1);

  // Next-state / counter decode; relock_req overrides every other event.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_retries_nxt = r_retries;
    w_loss_nxt    = r_loss;
    if (io_seq.relock_req) begin
      w_state_nxt = S_RESET_PLL;
      w_cnt_nxt   = '0;
      if (r_state == S_FAULT) w_retries_nxt = '0;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_cnt == RST_LAST) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_state_nxt = S_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == TMO_LAST) begin
            w_cnt_nxt     = '0;
            w_retries_nxt = w_retry_inc;
            w_state_nxt   = (w_retry_inc == RET_LIMIT) ? S_FAULT : S_RESET_PLL;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_STABLE: begin
          if (!w_locked_s) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_nxt   = S_RUN;
            w_cnt_nxt     = '0;
            w_retries_nxt = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_RUN: begin
          if (!w_locked_s) begin
            w_state_nxt = S_RESET_PLL;
            w_cnt_nxt   = '0;
            w_loss_nxt  = (r_loss == LOSS_SAT) ? r_loss : r_loss + LOSS_W'(1);
          end
        end
        S_FAULT: begin
          w_state_nxt = S_FAULT;
        end
        default: begin
          w_state_nxt = S_RESET_PLL;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counters, lock synchronizer and outputs; outputs decode the next state so they
  // change on the same edge as the state register.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_state     <= S_RESET_PLL;
      r_cnt       <= '0;
      r_retries   <= '0;
      r_loss      <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_sync1     <= io_seq.pll_locked;
      r_sync2     <= r_sync1;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retries   <= w_retries_nxt;
      r_loss      <= w_loss_nxt;
      r_pll_rst   <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAULT);
      r_sys_rst_n <= (w_state_nxt == S_RUN);
      r_ready     <= (w_state_nxt == S_RUN);
      r_fault     <= (w_state_nxt == S_FAULT);
    end
  end

  assign io_seq.pll_rst    = r_pll_rst;
  assign io_seq.sys_rst_n  = r_sys_rst_n;
  assign io_seq.ready      = r_ready;
  assign io_seq.fault      = r_fault;
  assign io_seq.retries    = r_retries;
  assign io_seq.loss_count = r_loss;
  assign io_seq.state      = 3'(r_state);
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios with literal expectations plus a random
// phase, all outputs compared every cycle against a timestamp-based behavioural model.
module tb_pll_reset_sequencer;
  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam int S_RST  = 0;
  localparam int S_WAIT = 1;
  localparam int S_STB  = 2;
  localparam int S_RUN  = 3;
  localparam int S_FLT  = 4;

  localparam int P_PLLRST = 0;
  localparam int P_READY  = 1;
  localparam int P_FAULT  = 2;
  localparam int P_WAIT   = 3;
  localparam int P_STABLE = 4;

  logic clkin = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .RST_CYCLES   (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR)
  ) dut (
    .clkin (clkin),
    .rst_n (rst_n),
    .io_seq(bus)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: each state is described by the edge at which it was entered, so
  // every dwell rule is "edges elapsed since entry". The synchronised lock seen at edge n
  // is the pll_locked level sampled two edges earlier, forced low for two edges after reset.
  int  m_edge     = 0;
  int  m_entry    = 0;
  int  m_last_rst = -1000;
  int  m_state    = 0;
  int  m_retries  = 0;
  int  m_loss     = 0;
  bit  m_valid    = 1'b0;
  bit  lk_q[$];

  task automatic m_goto(input int s);
    m_state = s;
    m_entry = m_edge;
  endtask

  always @(posedge clkin) begin : model_and_compare
    bit ls;
    int el;
    if (rst_n === 1'b0) begin
      m_goto(S_RST);
      m_retries  = 0;
      m_loss     = 0;
      m_last_rst = m_edge;
      m_valid    = 1'b1;
    end else if (m_valid) begin
      ls = (m_edge - m_last_rst >= 3) ? lk_q[$-1] : 1'b0;
      el = m_edge - m_entry;
      if (bus.relock_req === 1'b1) begin
        if (m_state == S_FLT) m_retries = 0;
        m_goto(S_RST);
      end else begin
        case (m_state)
          S_RST:  if (el == RC) m_goto(S_WAIT);
          S_WAIT: begin
            if (ls) m_goto(S_STB);
            else if (el == LT) begin
              m_retries++;
              m_goto((m_retries == MR) ? S_FLT : S_RST);
            end
          end
          // Lock sampled at edge E gives RUN at E+SC+3: 2 synchroniser edges, 1 to enter STABLE.
          S_STB: begin
            if (!ls) m_goto(S_WAIT);
            else if (el == SC + 1) begin
              m_retries = 0;
              m_goto(S_RUN);
            end
          end
          S_RUN: begin
            if (!ls) begin
              if (m_loss < 255) m_loss++;
              m_goto(S_RST);
            end
          end
          default: ;
        endcase
      end
    end
    lk_q.push_back(bus.pll_locked);
    if (lk_q.size() > 8) void'(lk_q.pop_front());
    m_edge++;
    #1;
    if (m_valid) begin
      chk("cyc_state",      32'(bus.state),      32'(m_state));
      chk("cyc_pll_rst",    32'(bus.pll_rst),    32'(m_state == S_RST || m_state == S_FLT));
      chk("cyc_sys_rst_n",  32'(bus.sys_rst_n),  32'(m_state == S_RUN));
      chk("cyc_ready",      32'(bus.ready),      32'(m_state == S_RUN));
      chk("cyc_fault",      32'(bus.fault),      32'(m_state == S_FLT));
      chk("cyc_retries",    32'(bus.retries),    32'(m_retries));
      chk("cyc_loss_count", 32'(bus.loss_count), 32'(m_loss));
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clkin);
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      P_PLLRST: return bus.pll_rst;
      P_READY:  return bus.ready;
      P_FAULT:  return bus.fault;
      P_WAIT:   return logic'(bus.state == 3'd1);
      P_STABLE: return logic'(bus.state == 3'd2);
      default:  return 1'bx;
    endcase
  endfunction

  task automatic wait_until(input string name, input int sel, input logic val, input int lim,
                            output int n);
    n = 0;
    while (probe(sel) !== val && n < lim) begin
      tick(1);
      n++;
    end
    if (probe(sel) !== val) chk({"timeout_", name}, 32'(probe(sel)), 32'(val));
  endtask

  initial begin : stimulus
    int n;
    int hi;
    int lows;
    int rises;
    logic prev;
    int r;

    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    bus.relock_req = 1'b0;
    tick(3);
    chk("rst_state",      32'(bus.state), 0);
    chk("rst_pll_rst",    32'(bus.pll_rst), 1);
    chk("rst_sys_rst_n",  32'(bus.sys_rst_n), 0);
    chk("rst_ready",      32'(bus.ready), 0);
    chk("rst_fault",      32'(bus.fault), 0);
    rst_n = 1'b1;

    // Basic bring-up: reset pulse width and lock-to-ready latency.
    hi = 0;
    while (bus.pll_rst === 1'b1 && hi < 50) begin
      hi++;
      tick(1);
    end
    chk("pll_rst_high_cycles", 32'(hi), 4);
    tick(3);
    bus.pll_locked = 1'b1;
    wait_until("ready_up", P_READY, 1'b1, 100, n);
    chk("lock_to_ready_edges", 32'(n - 1), 11);
    chk("bringup_sys_rst_n",   32'(bus.sys_rst_n), 1);
    chk("bringup_retries",     32'(bus.retries), 0);

    // Relock and lock loss hit the RUN state on the same edge.
    bus.pll_locked = 1'b0;
    tick(2);
    bus.relock_req = 1'b1;
    tick(1);
    bus.relock_req = 1'b0;
    chk("relock_vs_loss_state", 32'(bus.state), 0);
    chk("relock_vs_loss_loss",  32'(bus.loss_count), 0);
    bus.pll_locked = 1'b1;
    wait_until("ready_after_relock", P_READY, 1'b1, 100, n);

    // One-cycle lock glitch while STABLE has counted to 5.
    bus.relock_req = 1'b1;
    tick(1);
    bus.relock_req = 1'b0;
    wait_until("enter_stable", P_STABLE, 1'b1, 100, n);
    tick(3);
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    wait_until("glitch_to_wait", P_WAIT, 1'b1, 10, n);
    chk("glitch_to_wait_edges", 32'(n), 2);
    chk("glitch_retries",       32'(bus.retries), 0);
    wait_until("reenter_stable", P_STABLE, 1'b1, 10, n);
    wait_until("stable_to_run", P_READY, 1'b1, 50, n);
    chk("stable_dwell_edges", 32'(n), 9);

    // Repeated lock losses in RUN, loss counter saturates.
    for (int i = 0; i < 300; i++) begin
      bus.pll_locked = 1'b0;
      tick(1);
      bus.pll_locked = 1'b1;
      wait_until("loss_drop", P_READY, 1'b0, 10, n);
      chk("loss_sys_rst_n", 32'(bus.sys_rst_n), 0);
      chk("loss_state",     32'(bus.state), 0);
      wait_until("loss_recover", P_READY, 1'b1, 100, n);
    end
    chk("loss_saturated", 32'(bus.loss_count), 255);

    // One-cycle reset while in RUN.
    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("midrst_state",     32'(bus.state), 0);
    chk("midrst_pll_rst",   32'(bus.pll_rst), 1);
    chk("midrst_sys_rst_n", 32'(bus.sys_rst_n), 0);
    chk("midrst_ready",     32'(bus.ready), 0);
    chk("midrst_fault",     32'(bus.fault), 0);
    chk("midrst_retries",   32'(bus.retries), 0);
    chk("midrst_loss",      32'(bus.loss_count), 0);

    // No lock at all: two timed-out attempts then sticky FAULT.
    n = 0; lows = 0; rises = 0; prev = 1'b1;
    while (bus.fault !== 1'b1 && n < 100) begin
      tick(1);
      n++;
      if (bus.pll_rst === 1'b0) lows++;
      if (prev === 1'b0 && bus.pll_rst === 1'b1) rises++;
      prev = bus.pll_rst;
    end
    chk("fault_edges",     32'(n), 48);
    chk("fault_low_edges", 32'(lows), 40);
    chk("fault_rises",     32'(rises), 2);
    chk("fault_flag",      32'(bus.fault), 1);
    chk("fault_retries",   32'(bus.retries), 2);
    chk("fault_state",     32'(bus.state), 4);
    tick(10);
    chk("fault_sticky",    32'(bus.fault), 1);
    chk("fault_pll_rst",   32'(bus.pll_rst), 1);
    bus.relock_req = 1'b1;
    tick(1);
    bus.relock_req = 1'b0;
    chk("fault_relock_retries", 32'(bus.retries), 0);
    chk("fault_relock_state",   32'(bus.state), 0);

    // Random lock/relock/reset traffic, checked by the per-cycle model.
    for (int i = 0; i < 4000; i++) begin
      r              = int'($urandom_range(0, 999));
      rst_n          = (r < 3) ? 1'b0 : 1'b1;
      bus.relock_req = (r >= 3 && r < 10) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 39) == 0) bus.pll_locked = ~bus.pll_locked;
      tick(1);
    end
    rst_n          = 1'b1;
    bus.relock_req = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: number of clkin cycles the PLL reset is held per attempt (minimum 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: number of clkin cycles allowed in WAIT_LOCK before an attempt counts as failed.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: number of consecutive locked cycles required before release (minimum 1).
REQ-004 SHALL have parameter MAX_RETRIES, default 4: number of failed attempts that force FAULT (1..15).
REQ-005 SHALL have port clkin, input, 1 bit: the single clock (25 MHz board clock), rising edge only.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL lock flag, asynchronous to clkin.
REQ-008 SHALL have port relock_req, input, 1 bit: one-cycle request to restart the lock sequence.
REQ-009 SHALL have port pll_rst, output, 1 bit: drives the PLL RST pin, active-high.
REQ-010 SHALL have port sys_rst_n, output, 1 bit: downstream logic reset, active-low.
REQ-011 SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-012 SHALL have port fault, output, 1 bit: high only in state FAULT.
REQ-013 SHALL have port retries, output, 4 bits: failed attempts since the last RUN entry or reset.
REQ-014 SHALL have port loss_count, output, 8 bits: lock losses seen while in RUN, saturating.
REQ-015 SHALL have port state, output, 3 bits: encoding RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.

Function
REQ-016 SHALL pass pll_locked through a 2-flop synchronizer to form locked_s; all decisions SHALL use locked_s only.
REQ-017 SHALL register all outputs; every output SHALL be a direct decode of the state and counter registers.
REQ-018 SHALL behave in RESET_PLL as follows: pll_rst=1; cycle counter runs; after RST_CYCLES cycles, go to WAIT_LOCK with the counter cleared.
REQ-019 SHALL behave in WAIT_LOCK as follows: pll_rst=0; if locked_s=1, go to STABLE with the counter cleared.
REQ-020 SHALL, in WAIT_LOCK, treat LOCK_TIMEOUT cycles without lock as a failed attempt: retries+1; if the new value equals MAX_RETRIES, go to FAULT, else go to RESET_PLL.
REQ-021 SHALL behave in STABLE as follows: count consecutive locked_s=1 cycles; any locked_s=0 returns to WAIT_LOCK with the counter cleared and no retry increment.
REQ-022 SHALL, in STABLE, go to RUN on reaching STABLE_CYCLES, clearing retries.
REQ-023 SHALL hold sys_rst_n=0 in every state except RUN.
REQ-024 SHALL assert sys_rst_n and ready on the clkin edge STABLE_CYCLES+3 edges after the first edge that samples pll_locked high, given no lock drop in between.
REQ-025 SHALL, in RUN on locked_s=0, increment loss_count (saturating at 255) and go to RESET_PLL; sys_rst_n SHALL fall on that same transition edge.
REQ-026 SHALL, on relock_req=1 in any state, go to RESET_PLL with the counter cleared and no loss_count change; in FAULT, relock_req SHALL also clear retries.
REQ-027 SHALL give relock_req priority when it coincides with lock loss, timeout or stable completion: loss_count and retries stay unchanged.
REQ-028 SHALL make FAULT sticky: pll_rst=1, sys_rst_n=0, fault=1 until rst_n or relock_req.
REQ-029 SHALL size counters to hold the maximum of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES; counters SHALL never wrap.

Reset
REQ-030 SHALL, on a clkin edge with rst_n=0, set: state=RESET_PLL, counter=0, retries=0, loss_count=0, synchronizer=0, pll_rst=1, sys_rst_n=0, ready=0, fault=0.
REQ-031 SHALL apply reset mid-operation (e.g. in RUN) with full effect on the same edge, with no partial counts retained.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-032 SHALL be covered by a bench: release rst_n, raise pll_locked 3 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; ready and sys_rst_n rise 11 edges after the first edge sampling lock; retries=0.
REQ-033 SHALL be covered by a bench: pll_locked held 0 -> two pll_rst pulses of 4 cycles, 20 cycles apart in WAIT_LOCK; fault=1, retries=2, state=4; relock_req -> retries=0, state=0.
REQ-034 SHALL be covered by a bench: in STABLE, drop pll_locked for 1 cycle at count 5 -> return to WAIT_LOCK; full 8-cycle count restarts; retries unchanged.
REQ-035 SHALL be covered by a bench: in RUN, drop pll_locked 300 times -> each drop gives sys_rst_n=0 and state=0; loss_count saturates at 255.
REQ-036 SHALL be covered by a bench: in RUN, relock_req and lock drop on the same cycle -> state=0, loss_count unchanged.
REQ-037 SHALL be covered by a bench: rst_n low for 1 cycle while in RUN -> all outputs at REQ-030 values on the next edge.
